// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
//   Program loader for the 16-bit CPU. Takes field-level instruction bundles
//   over a valid/ready handshake and packs each one into the 16-bit word format
//   the decoder expects. Words are written one at a time into instruction
//   memory, starting at BASE_ADDR. The CPU is held in stall while loading.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : synchronous, active-low reset
//   start      : pulse; restart loading at BASE_ADDR
//   in_valid   : bundle valid            in_ready  : bundle accepted this cycle
//   in_last    : final instruction       in_class  : instruction class
//   in_opcode  : R-type opcode byte      in_cond   : jump/branch condition
//   in_rdst    : destination register    in_rsrc   : source register
//   in_imm     : immediate / displacement
//   mem_we     : memory write strobe     mem_addr  : write address
//   mem_wdata  : encoded word            cpu_stall : loader owns memory
//   load_done  : program fully loaded    full      : DEPTH words written, no last
//   err        : one-cycle pulse, illegal bundle rejected
// -----------------------------------------------------------------------------
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        in_class,
  input  logic [7:0]        in_opcode,
  input  logic [3:0]        in_cond,
  input  logic [3:0]        in_rdst,
  input  logic [3:0]        in_rsrc,
  input  logic [7:0]        in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_stall,
  output logic              load_done,
  output logic              full,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_FULL
  } state_t;

  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + DEPTH - 1);

  state_t      state, next_state;
  logic        last_q;
  logic        accept;
  logic        cond_ok;
  logic        enc_legal;
  logic [15:0] enc_word;

  assign accept = in_valid & in_ready;

  // Field packing and legality check for the bundle currently on the inputs.
  // NOTE: every always_comb output is given a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    enc_word  = 16'h0000;
    enc_legal = 1'b0;
    cond_ok   = (in_cond inside {4'h0, 4'h1, 4'h6, 4'h7, 4'hE});
    case (in_class)
      4'b0001: begin
        enc_word  = {in_opcode, in_rdst, in_rsrc};
        enc_legal = (in_opcode inside {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                       8'h08, 8'h09, 8'h0B, 8'h0C, 8'h0F, 8'h84});
      end
      4'b0010: begin
        enc_word  = {4'b0101, in_rdst, in_imm};
        enc_legal = 1'b1;
      end
      4'b0100: begin
        enc_word  = {8'h85, in_rdst, in_rsrc};
        enc_legal = 1'b1;
      end
      4'b0101: begin
        enc_word  = {8'h87, in_rdst, in_rsrc};
        enc_legal = 1'b1;
      end
      4'b0000: begin
        enc_word  = 16'h0000;
        enc_legal = 1'b1;
      end
      4'b1000: begin
        enc_word  = (in_cond == 4'hE) ? {8'h4E, in_imm} : {4'b0100, in_cond, in_imm};
        enc_legal = cond_ok;
      end
      4'b1100: begin
        enc_word  = (in_cond == 4'hE) ? {8'hCE, in_imm} : {4'b1100, in_cond, in_imm};
        enc_legal = cond_ok;
      end
      default: ;
    endcase
  end

  // Next-state logic; start overrides everything, including a pending accept.
  always_comb begin
    next_state = state;
    case (state)
      S_LOAD:  if (accept && enc_legal) next_state = S_WRITE;
      S_WRITE: begin
        if (last_q)                     next_state = S_DONE;
        else if (mem_addr == LAST_ADDR) next_state = S_FULL;
        else                            next_state = S_LOAD;
      end
      default: ;
    endcase
    if (start) next_state = S_LOAD;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      mem_addr  <= FIRST_ADDR;
      mem_wdata <= 16'h0000;
      last_q    <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= next_state;
      err   <= accept & ~enc_legal & ~start;
      if (start)
        mem_addr <= FIRST_ADDR;
      else if (state == S_WRITE && next_state == S_LOAD)
        mem_addr <= mem_addr + 1'b1;
      if (accept && enc_legal && !start) begin
        mem_wdata <= enc_word;
        last_q    <= in_last;
      end
    end
  end

  // A start arriving during WRITE drops the pending word before it lands.
  assign mem_we    = (state == S_WRITE) && !start;
  assign in_ready  = (state == S_LOAD);
  assign cpu_stall = (state == S_LOAD) || (state == S_WRITE) || (state == S_FULL);
  assign load_done = (state == S_DONE);
  assign full      = (state == S_FULL);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder_loader
//   Directed bench for instr_encoder_loader, built with DEPTH=4 so the full
//   boundary is reachable quickly. Inputs change 1 ns after a rising edge and
//   outputs are sampled at the same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_instr_encoder_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_last = 1'b0;
  logic [3:0]        in_class = 4'h0;
  logic [7:0]        in_opcode = 8'h00;
  logic [3:0]        in_cond = 4'h0;
  logic [3:0]        in_rdst = 4'h0;
  logic [3:0]        in_rsrc = 4'h0;
  logic [7:0]        in_imm = 8'h00;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              cpu_stall;
  logic              load_done;
  logic              full;
  logic              err;

  int checks = 0;
  int errors = 0;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(4), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_class(in_class), .in_opcode(in_opcode), .in_cond(in_cond),
    .in_rdst(in_rdst), .in_rsrc(in_rsrc), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_stall(cpu_stall), .load_done(load_done), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Presents one bundle and holds it until accepted (bounded). Returns with
  // the accepting edge just passed, i.e. inside the WRITE cycle.
  task automatic send(input logic [3:0] cls, input logic [7:0] op, input logic [3:0] cond,
                      input logic [3:0] rd, input logic [3:0] rs, input logic [7:0] imm,
                      input logic last, output bit ok);
    int wait_cnt;
    in_class = cls; in_opcode = op; in_cond = cond;
    in_rdst = rd; in_rsrc = rs; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    ok = 1'b0;
    wait_cnt = 0;
    while (!ok && wait_cnt < 20) begin
      if (in_ready) ok = 1'b1;
      step();
      wait_cnt++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b1;
    step(); step();
    in_valid = 1'b0;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", mem_we); end checks++;
    if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", mem_addr); end checks++;
    if (mem_wdata !== 16'h0000) begin errors++; $display("FAIL reset_wdata got %h exp 0000", mem_wdata); end checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", in_ready); end checks++;
    if ({cpu_stall, load_done, full, err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {cpu_stall, load_done, full, err});
    end checks++;
    reset = 1'b1;
    step();
    if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b exp 0", in_ready); end checks++;
  endtask

  task automatic test_r_add();
    bit ok;
    do_start();
    if (in_ready !== 1'b1 || cpu_stall !== 1'b1) begin
      errors++; $display("FAIL load_entry got ready=%b stall=%b exp 1 1", in_ready, cpu_stall);
    end checks++;
    send(4'b0001, 8'h05, 4'h0, 4'h3, 4'h4, 8'h00, 1'b0, ok);
    if (!ok) begin errors++; $display("FAIL r_add_accept got timeout exp accept"); end checks++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 16'h0534) begin
      errors++; $display("FAIL r_add_write got we=%b addr=%h data=%h exp 1 00 0534", mem_we, mem_addr, mem_wdata);
    end checks++;
    step();
    if (mem_we !== 1'b0 || mem_addr !== 8'h01 || in_ready !== 1'b1) begin
      errors++; $display("FAIL r_add_after got we=%b addr=%h ready=%b exp 0 01 1", mem_we, mem_addr, in_ready);
    end checks++;
  endtask

  task automatic test_addi_branch_jump();
    bit ok;
    do_start();
    send(4'b0010, 8'h00, 4'h0, 4'h2, 4'h0, 8'h7F, 1'b0, ok);
    if (mem_we !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 16'h527F) begin
      errors++; $display("FAIL addi_write got we=%b addr=%h data=%h exp 1 00 527F", mem_we, mem_addr, mem_wdata);
    end checks++;
    send(4'b1100, 8'h00, 4'h1, 4'h0, 4'h0, 8'hF0, 1'b0, ok);
    if (mem_we !== 1'b1 || mem_addr !== 8'h01 || mem_wdata !== 16'hC1F0) begin
      errors++; $display("FAIL bne_write got we=%b addr=%h data=%h exp 1 01 C1F0", mem_we, mem_addr, mem_wdata);
    end checks++;
    send(4'b1000, 8'h00, 4'hE, 4'h0, 4'h0, 8'h10, 1'b1, ok);
    if (mem_we !== 1'b1 || mem_addr !== 8'h02 || mem_wdata !== 16'h4E10) begin
      errors++; $display("FAIL jmp_write got we=%b addr=%h data=%h exp 1 02 4E10", mem_we, mem_addr, mem_wdata);
    end checks++;
    step();
    if (load_done !== 1'b1 || cpu_stall !== 1'b0 || in_ready !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL done_state got done=%b stall=%b ready=%b we=%b exp 1 0 0 0",
                         load_done, cpu_stall, in_ready, mem_we);
    end checks++;
  endtask

  task automatic test_illegal();
    bit ok;
    logic [3:0] bad_cls  [3] = '{4'b0001, 4'b1000, 4'b0011};
    logic [7:0] bad_op   [3] = '{8'h0A, 8'h00, 8'h00};
    logic [3:0] bad_cond [3] = '{4'h0, 4'h2, 4'h0};
    do_start();
    if (load_done !== 1'b0) begin errors++; $display("FAIL restart_done got %b exp 0", load_done); end checks++;
    for (int i = 0; i < 3; i++) begin
      send(bad_cls[i], bad_op[i], bad_cond[i], 4'h1, 4'h2, 8'h33, 1'b1, ok);
      if (err !== 1'b1 || mem_we !== 1'b0 || in_ready !== 1'b1 || mem_addr !== 8'h00) begin
        errors++; $display("FAIL illegal_%0d got err=%b we=%b ready=%b addr=%h exp 1 0 1 00",
                           i, err, mem_we, in_ready, mem_addr);
      end checks++;
      step();
      if (err !== 1'b0) begin errors++; $display("FAIL illegal_pulse_%0d got %b exp 0", i, err); end checks++;
    end
    send(4'b0001, 8'h84, 4'h0, 4'h1, 4'h2, 8'h00, 1'b0, ok);
    if (mem_we !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 16'h8412 || err !== 1'b0) begin
      errors++; $display("FAIL legal_after got we=%b addr=%h data=%h err=%b exp 1 00 8412 0",
                         mem_we, mem_addr, mem_wdata, err);
    end checks++;
  endtask

  task automatic test_encodings();
    bit ok;
    do_start();
    send(4'b0100, 8'h00, 4'h0, 4'h1, 4'h2, 8'h00, 1'b0, ok);
    if (mem_addr !== 8'h00 || mem_wdata !== 16'h8512) begin
      errors++; $display("FAIL load_enc got addr=%h data=%h exp 00 8512", mem_addr, mem_wdata);
    end checks++;
    send(4'b0101, 8'h00, 4'h0, 4'hF, 4'h0, 8'h00, 1'b0, ok);
    if (mem_addr !== 8'h01 || mem_wdata !== 16'h87F0) begin
      errors++; $display("FAIL store_enc got addr=%h data=%h exp 01 87F0", mem_addr, mem_wdata);
    end checks++;
    send(4'b0000, 8'hFF, 4'h0, 4'hF, 4'hF, 8'hFF, 1'b0, ok);
    if (mem_we !== 1'b1 || mem_addr !== 8'h02 || mem_wdata !== 16'h0000) begin
      errors++; $display("FAIL wait_enc got we=%b addr=%h data=%h exp 1 02 0000", mem_we, mem_addr, mem_wdata);
    end checks++;
    send(4'b1100, 8'h00, 4'hE, 4'h0, 4'h0, 8'h55, 1'b0, ok);
    if (mem_addr !== 8'h03 || mem_wdata !== 16'hCE55) begin
      errors++; $display("FAIL bra_enc got addr=%h data=%h exp 03 CE55", mem_addr, mem_wdata);
    end checks++;
    step();
    if (full !== 1'b1 || cpu_stall !== 1'b1 || mem_addr !== 8'h03) begin
      errors++; $display("FAIL enc_full got full=%b stall=%b addr=%h exp 1 1 03", full, cpu_stall, mem_addr);
    end checks++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int we_seen;
    do_start();
    for (int i = 0; i < 4; i++) begin
      send(4'b0010, 8'h00, 4'h0, 4'(i), 4'h0, 8'(i + 16), 1'b0, ok);
      if (!ok || mem_we !== 1'b1 || mem_addr !== 8'(i) || mem_wdata !== {4'b0101, 4'(i), 8'(i + 16)}) begin
        errors++; $display("FAIL b2b_%0d got ok=%b we=%b addr=%h data=%h exp 1 1 %h %h", i, ok, mem_we,
                           mem_addr, mem_wdata, 8'(i), {4'b0101, 4'(i), 8'(i + 16)});
      end checks++;
    end
    in_class = 4'b0010; in_valid = 1'b1;
    we_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (mem_we) we_seen++;
    end
    if (full !== 1'b1 || in_ready !== 1'b0 || we_seen != 0 || mem_addr !== 8'h03) begin
      errors++; $display("FAIL b2b_full got full=%b ready=%b writes=%0d addr=%h exp 1 0 0 03",
                         full, in_ready, we_seen, mem_addr);
    end checks++;
    in_valid = 1'b0;
  endtask

  task automatic test_restart();
    bit ok;
    do_start();
    send(4'b0010, 8'h00, 4'h0, 4'h1, 4'h0, 8'h11, 1'b0, ok);
    start = 1'b1;
    #1;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL restart_drop got we=%b exp 0", mem_we); end checks++;
    step();
    start = 1'b0;
    if (in_ready !== 1'b1 || mem_addr !== 8'h00 || mem_we !== 1'b0) begin
      errors++; $display("FAIL restart_state got ready=%b addr=%h we=%b exp 1 00 0", in_ready, mem_addr, mem_we);
    end checks++;
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    send(4'b0001, 8'h01, 4'h0, 4'h5, 4'h6, 8'h00, 1'b0, ok);
    if (mem_we !== 1'b1 || mem_wdata !== 16'h0156) begin
      errors++; $display("FAIL prereset_write got we=%b data=%h exp 1 0156", mem_we, mem_wdata);
    end checks++;
    reset = 1'b0;
    step();
    if (mem_we !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 16'h0000 || in_ready !== 1'b0 ||
        {cpu_stall, load_done, full, err} !== 4'b0000) begin
      errors++; $display("FAIL midwrite_reset got we=%b addr=%h data=%h ready=%b flags=%b exp 0 00 0000 0 0000",
                         mem_we, mem_addr, mem_wdata, in_ready, {cpu_stall, load_done, full, err});
    end checks++;
    reset = 1'b1;
    step();
    if (in_ready !== 1'b0 || cpu_stall !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got ready=%b stall=%b exp 0 0", in_ready, cpu_stall);
    end checks++;
  endtask

  initial begin
    #1;
    test_reset();
    test_r_add();
    test_addi_branch_jump();
    test_illegal();
    test_encodings();
    test_back_to_back();
    test_restart();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
